drum_voice_scheduler: RTL and testbench
=======================================

Name: drum_voice_scheduler

Overview:
- Sequences a 16-step drum pattern and time-multiplexes one shared single-port sample ROM across NUM_VOICES drum voices (hihat, kick, snare, clap).
- On each sample tick, reads one sample per active voice in fixed voice order, sums the samples with saturation, applies master volume and emits one mixed 16-bit sample.
- Sits between the step-timing counter and the audio DAC driver.
- Replaces the per-track private ROMs, so all tracks share one ROM.

Parameters:
- NUM_VOICES, 4, number of voices/tracks (1..8).
- ADDR_W, 13, sample ROM address width.
- ROM_LAT, 1, ROM read latency in clocks (1..3).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- step_tick  in  1  one-cycle pulse; fires the current step and advances it.
- sample_tick  in  1  one-cycle pulse at the audio sample rate; starts one mix frame.
- pattern  in  NUM_VOICES*16  bit v*16+s = voice v fires at step s.
- voice_base  in  NUM_VOICES*ADDR_W  start address of each voice's sample.
- voice_len  in  NUM_VOICES*ADDR_W  length in samples of each voice's sample.
- volume  in  3  master volume; 0 = mute.
- rom_addr  out  ADDR_W  shared ROM address.
- rom_data  in  16  signed ROM data, valid ROM_LAT cycles after rom_addr.
- audio  out  16  signed mixed sample.
- audio_valid  out  1  one-cycle pulse when audio updates.
- step  out  4  index of the next step to fire.
- active  out  NUM_VOICES  voice currently playing.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous, reset=0): all outputs 0. step, active, pending triggers, per-voice offsets, accumulator and FSM (forced to IDLE) are cleared. This holds mid-frame too: no partial audio_valid is ever emitted.
- Step counter:
  - On step_tick, each voice v with pattern[v*16+step]=1 sets pending[v].
  - step then increments mod 16 (15→0).
- FSM: IDLE, ISSUE, WAIT, ACC, OUT.
- IDLE:
  - On sample_tick, apply (pending | same-cycle step_tick triggers) and clear pending.
  - For each triggered v with voice_len≠0: set active[v] and offset[v]=0. A retrigger of an already active voice restarts it.
  - A trigger on a voice with voice_len=0 is discarded.
  - Clear the 19-bit signed accumulator, set vidx=0, go to ISSUE.
- ISSUE:
  - If active[vidx]: rom_addr = voice_base[vidx] + offset[vidx] (mod 2^ADDR_W). Go to WAIT if ROM_LAT>1, else to ACC.
  - If inactive: rom_addr holds its previous value; go to the next voice, or to OUT after the last voice.
- WAIT: holds for ROM_LAT-1 cycles, then goes to ACC.
- ACC:
  - acc += sign-extended rom_data.
  - If offset[vidx] = voice_len[vidx]-1: clear active[vidx]. Otherwise offset++.
  - Go to the next voice, or to OUT after the last voice.
- OUT:
  - Saturate acc to [-32768, 32767].
  - If volume=0, audio=0; else audio = saturated value >>> (7-volume), an arithmetic shift (volume 7 = unity).
  - Pulse audio_valid; return to IDLE.
  - audio holds its value between frames.
- Frame length: the sample_tick cycle is cycle 0; audio_valid is high at cycle 2 + Σ(active ? 1+ROM_LAT : 1).
  - NUM_VOICES=4, ROM_LAT=1, all voices active: cycle 10.
  - All voices idle: cycle 6, audio=0.
- busy is high from the cycle after sample_tick through the OUT cycle.
- A sample_tick while busy is dropped.
- A step_tick while busy still latches pending triggers; they apply at the next frame.
- active bits change only inside frames (IDLE trigger apply, or ACC end-of-sample).

Optional Feature:
- DVS_OVERRUN_CNT_EN defined: adds output overrun_cnt[7:0].
  - Increments on each sample_tick received while busy=1.
  - Saturates at 255.
  - Cleared only by reset.
- Not defined: the port is absent, and dropped sample_ticks leave no trace.

Test Plan:
- Reset release, no ticks → audio=0, audio_valid=0, step=0, active=0, busy=0 and rom_addr=0, held indefinitely.
- pattern bit 0 set (voice 0, step 0), base0=100, len0=3, ROM[n]=n; step_tick then 3 sample_ticks 20 cycles apart, volume=7 → rom_addr 100, 101, 102; audio 100, 101, 102; active[0] clears after the third frame; step=1.
- All 4 voices triggered, every ROM word 16'h7000, volume=7 → acc = 4×28672 saturates, audio=16'h7FFF, audio_valid exactly 10 cycles after sample_tick; the same frame with volume=0 → audio=0.
- 16 step_ticks with only pattern bit 15 set → exactly one trigger (on the 16th tick); step returns to 0.
- sample_tick re-pulsed 3 cycles into a frame → pulse ignored, single audio_valid; with DVS_OVERRUN_CNT_EN, overrun_cnt=1.
- reset asserted while the FSM is in ACC with 2 voices active → all outputs 0 immediately; no audio_valid after release until the next sample_tick.

Source files
------------

// File: rtl/drum_voice_scheduler.sv
// drum_voice_scheduler
// 16-step drum sequencer. It shares one single-port sample ROM across
// NUM_VOICES voices by reading one sample per active voice in fixed voice
// order. Each sample_tick produces one saturated, volume-scaled mixed sample.
// Ports:
//   clk, reset                     : clock, asynchronous active-low reset
//   step_tick                      : fire current step, then advance it
//   sample_tick                    : start one mix frame
//   pattern                        : bit v*16+s = voice v fires at step s
//   voice_base, voice_len          : per-voice sample start address / length
//   volume                         : master volume (0 = mute, 7 = unity)
//   rom_addr, rom_data             : shared ROM, data valid ROM_LAT clocks after address
//   audio, audio_valid             : mixed sample and its one-cycle update strobe
//   step, active, busy             : next step, playing voices, frame in progress
// Optional: define DVS_OVERRUN_CNT_EN to add overrun_cnt[7:0]. It is a
// saturating count of sample_ticks that were dropped because a frame was in
// progress.
module drum_voice_scheduler #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned ROM_LAT    = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         step_tick,
    input  logic                         sample_tick,
    input  logic [NUM_VOICES*16-1:0]     pattern,
    input  logic [NUM_VOICES*ADDR_W-1:0] voice_base,
    input  logic [NUM_VOICES*ADDR_W-1:0] voice_len,
    input  logic [2:0]                   volume,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [15:0]                  rom_data,
    output logic [15:0]                  audio,
    output logic                         audio_valid,
    output logic [3:0]                   step,
    output logic [NUM_VOICES-1:0]        active,
    output logic                         busy
`ifdef DVS_OVERRUN_CNT_EN
    ,
    output logic [7:0]                   overrun_cnt
`endif
);

    localparam int unsigned VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned WCNT_W = 2;
    localparam int unsigned ACC_W  = 19;
    localparam logic signed [ACC_W-1:0] SAT_MAX = 19'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -19'sd32768;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACC, S_OUT} state_t;

    state_t                  state, state_d;
    logic [VIDX_W-1:0]       vidx, vidx_d;
    logic [WCNT_W-1:0]       wcnt, wcnt_d;
    logic signed [ACC_W-1:0] acc, acc_d;
    logic [ADDR_W-1:0]       offset   [NUM_VOICES];
    logic [ADDR_W-1:0]       offset_d [NUM_VOICES];
    logic [ADDR_W-1:0]       base_a   [NUM_VOICES];
    logic [ADDR_W-1:0]       len_a    [NUM_VOICES];
    logic [15:0]             pat_row  [NUM_VOICES];
    logic [NUM_VOICES-1:0]   pending, pending_d, active_d, fires, trig;
    logic [3:0]              step_d;
    logic [ADDR_W-1:0]       rom_addr_d;
    logic [15:0]             audio_d;
    logic                    audio_valid_d;
    logic signed [15:0]      sat;
    logic                    last_voice;

    // Unpack the flat per-voice buses and look up the current step's triggers
    always_comb begin
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            base_a[v]  = voice_base[v*ADDR_W +: ADDR_W];
            len_a[v]   = voice_len[v*ADDR_W +: ADDR_W];
            pat_row[v] = pattern[v*16 +: 16];
            fires[v]   = pat_row[v][step];
        end
    end

    assign last_voice = (vidx == VIDX_W'(NUM_VOICES - 1));
    // A step_tick in the same cycle as an accepted sample_tick joins this frame
    assign trig = pending | (step_tick ? fires : '0);

    // Clamp the wide accumulator to the 16-bit signed range
    always_comb begin
        if (acc > SAT_MAX) begin
            sat = 16'sh7FFF;
        end else if (acc < SAT_MIN) begin
            sat = -16'sh8000;
        end else begin
            sat = acc[15:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (sample_tick) state_d = S_ISSUE;
            S_ISSUE: begin
                if (active[vidx]) begin
                    state_d = (ROM_LAT > 1) ? S_WAIT : S_ACC;
                end else if (last_voice) begin
                    state_d = S_OUT;
                end
            end
            S_WAIT:  if (wcnt == WCNT_W'(ROM_LAT - 2)) state_d = S_ACC;
            S_ACC:   state_d = last_voice ? S_OUT : S_ISSUE;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values; every output is registered from these
    always_comb begin
        step_d        = step;
        pending_d     = pending;
        active_d      = active;
        offset_d      = offset;
        vidx_d        = vidx;
        wcnt_d        = wcnt;
        acc_d         = acc;
        rom_addr_d    = rom_addr;
        audio_d       = audio;
        audio_valid_d = 1'b0;

        if (step_tick) begin
            step_d    = step + 4'd1;
            pending_d = pending | fires;
        end

        case (state)
            S_IDLE: begin
                if (sample_tick) begin
                    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                        // zero-length voices discard their trigger
                        if (trig[v] && (len_a[v] != '0)) begin
                            active_d[v] = 1'b1;
                            offset_d[v] = '0;
                        end
                    end
                    pending_d = '0;
                    acc_d     = '0;
                    vidx_d    = '0;
                end
            end
            S_ISSUE: begin
                wcnt_d = '0;
                if (!active[vidx] && !last_voice) vidx_d = vidx + VIDX_W'(1);
            end
            S_WAIT: begin
                wcnt_d = wcnt + WCNT_W'(1);
            end
            S_ACC: begin
                acc_d = acc + ACC_W'($signed(rom_data));
                if (offset[vidx] == len_a[vidx] - ADDR_W'(1)) begin
                    active_d[vidx] = 1'b0;
                end else begin
                    offset_d[vidx] = offset[vidx] + ADDR_W'(1);
                end
                if (!last_voice) vidx_d = vidx + VIDX_W'(1);
            end
            S_OUT: begin
                audio_d       = (volume == 3'd0) ? 16'd0 : 16'(sat >>> (3'd7 - volume));
                audio_valid_d = 1'b1;
            end
            default: ;
        endcase

        // Address is registered on entry to ISSUE so it is stable for the whole ISSUE cycle
        if ((state_d == S_ISSUE) && active_d[vidx_d]) begin
            rom_addr_d = base_a[vidx_d] + offset_d[vidx_d];
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step        <= '0;
            pending     <= '0;
            active      <= '0;
            vidx        <= '0;
            wcnt        <= '0;
            acc         <= '0;
            rom_addr    <= '0;
            audio       <= '0;
            audio_valid <= 1'b0;
            busy        <= 1'b0;
            for (int unsigned v = 0; v < NUM_VOICES; v++) offset[v] <= '0;
        end else begin
            step        <= step_d;
            pending     <= pending_d;
            active      <= active_d;
            vidx        <= vidx_d;
            wcnt        <= wcnt_d;
            acc         <= acc_d;
            rom_addr    <= rom_addr_d;
            audio       <= audio_d;
            audio_valid <= audio_valid_d;
            busy        <= (state_d != S_IDLE);
            for (int unsigned v = 0; v < NUM_VOICES; v++) offset[v] <= offset_d[v];
        end
    end

`ifdef DVS_OVERRUN_CNT_EN
    // Saturating count of sample_ticks dropped mid-frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_cnt <= '0;
        end else if (sample_tick && (state != S_IDLE) && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_drum_voice_scheduler.sv
// tb_drum_voice_scheduler
// Testbench for drum_voice_scheduler. A synchronous ROM model has a latency of
// one clock. A frame-level reference model tracks the pending triggers and the
// playback position of each voice.
`timescale 1ns/1ps
module tb_drum_voice_scheduler;

    localparam int NV = 4;
    localparam int AW = 13;
    localparam int NVEC = 13;

    logic            clk = 1'b0;
    logic            reset;
    logic            step_tick;
    logic            sample_tick;
    logic [NV*16-1:0] pattern;
    logic [NV*AW-1:0] voice_base;
    logic [NV*AW-1:0] voice_len;
    logic [2:0]      volume;
    logic [AW-1:0]   rom_addr;
    logic [15:0]     rom_data;
    logic [15:0]     audio;
    logic            audio_valid;
    logic [3:0]      step;
    logic [NV-1:0]   active;
    logic            busy;
`ifdef DVS_OVERRUN_CNT_EN
    logic [7:0]      overrun_cnt;
`endif

    logic [15:0] mem [1<<AW];
    int n_checks = 0;
    int n_fail   = 0;
    int av_count = 0;

    // reference model state
    bit m_play [NV];
    int m_pos  [NV];
    bit m_pend [NV];
    int m_step;

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] word;
        logic [2:0]  vol;
        logic [15:0] exp_audio;
        int          exp_lat;
    } vec_t;
    vec_t vecs [NVEC];

    drum_voice_scheduler #(.NUM_VOICES(NV), .ADDR_W(AW), .ROM_LAT(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .step_tick   (step_tick),
        .sample_tick (sample_tick),
        .pattern     (pattern),
        .voice_base  (voice_base),
        .voice_len   (voice_len),
        .volume      (volume),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .audio       (audio),
        .audio_valid (audio_valid),
        .step        (step),
        .active      (active),
        .busy        (busy)
`ifdef DVS_OVERRUN_CNT_EN
        ,
        .overrun_cnt (overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= mem[rom_addr];

    always @(negedge clk) if (audio_valid === 1'b1) av_count++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int vlen(input int v);
        return int'(voice_len[v*AW +: AW]);
    endfunction

    function automatic int vbase(input int v);
        return int'(voice_base[v*AW +: AW]);
    endfunction

    function automatic logic [NV-1:0] m_active();
        logic [NV-1:0] a;
        for (int v = 0; v < NV; v++) a[v] = m_play[v];
        return a;
    endfunction

    function automatic void m_reset();
        for (int v = 0; v < NV; v++) begin
            m_play[v] = 0;
            m_pos[v]  = 0;
            m_pend[v] = 0;
        end
        m_step = 0;
    endfunction

    function automatic void m_step_tick();
        for (int v = 0; v < NV; v++) if (pattern[v*16 + m_step]) m_pend[v] = 1;
        m_step = (m_step + 1) % 16;
    endfunction

    // One mix frame: apply triggers, sum one sample per playing voice, clamp, scale
    task automatic m_frame(output logic [15:0] ea, output int elat);
        int sum;
        sum  = 0;
        elat = 2;
        for (int v = 0; v < NV; v++) begin
            if (m_pend[v] && vlen(v) != 0) begin
                m_play[v] = 1;
                m_pos[v]  = 0;
            end
            m_pend[v] = 0;
        end
        for (int v = 0; v < NV; v++) begin
            if (m_play[v]) begin
                sum += int'($signed(mem[(vbase(v) + m_pos[v]) % (1 << AW)]));
                elat += 2;
                m_pos[v]++;
                if (m_pos[v] == vlen(v)) m_play[v] = 0;
            end else begin
                elat += 1;
            end
        end
        if (sum > 32767)  sum = 32767;
        if (sum < -32768) sum = -32768;
        ea = (volume == 3'd0) ? 16'h0 : 16'(sum >>> (7 - int'(volume)));
    endtask

    task automatic pulse_step();
        @(posedge clk); #1;
        step_tick = 1'b1;
        m_step_tick();
        @(posedge clk); #1;
        step_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset       = 1'b0;
        step_tick   = 1'b0;
        sample_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        m_reset();
    endtask

    // Run one frame and compare it against the model; optional step_tick on the
    // tick cycle and/or in the middle of the frame
    task automatic do_frame(input bit with_step, input bit mid_step,
                            output logic [15:0] got_audio, output int got_lat,
                            output logic [AW-1:0] addr1);
        logic [15:0] ea;
        int elat;
        int cyc;
        bit got;
        @(posedge clk); #1;
        sample_tick = 1'b1;
        step_tick   = with_step;
        if (with_step) m_step_tick();
        m_frame(ea, elat);
        @(posedge clk); #1;
        sample_tick = 1'b0;
        step_tick   = 1'b0;
        cyc   = 1;
        got   = 0;
        addr1 = '0;
        while (cyc < 64) begin
            @(negedge clk);
            if (cyc == 1) begin
                addr1 = rom_addr;
                check("frame_busy", 32'(busy), 32'd1);
            end
            if (audio_valid === 1'b1) begin
                got = 1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
            step_tick = mid_step && (cyc == 2);
            if (mid_step && cyc == 2) m_step_tick();
        end
        step_tick = 1'b0;
        got_audio = audio;
        got_lat   = cyc;
        check("frame_done", 32'(got), 32'd1);
        check("frame_latency", 32'(cyc), 32'(elat));
        check("frame_audio", 32'(audio), 32'(ea));
        check("frame_active", 32'(active), 32'(m_active()));
        check("frame_step", 32'(step), 32'(m_step));
    endtask

    initial begin
        logic [15:0] ga;
        int gl;
        logic [AW-1:0] ga1;
        int start;

        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0;
        reset       = 1'b0;
        step_tick   = 1'b0;
        sample_tick = 1'b0;
        pattern     = '0;
        voice_base  = '0;
        voice_len   = '0;
        volume      = 3'd7;
        m_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // idle after reset: everything stays zero
        for (int k = 0; k < 3; k++) begin
            repeat (7) @(posedge clk);
            @(negedge clk);
            check("rst_audio", 32'(audio), 32'd0);
            check("rst_audio_valid", 32'(audio_valid), 32'd0);
            check("rst_step", 32'(step), 32'd0);
            check("rst_active", 32'(active), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_rom_addr", 32'(rom_addr), 32'd0);
        end

        // single-sample voices, one frame per vector
        vecs[0]  = '{4'hF, 16'h7000, 3'd7, 16'h7FFF, 10};
        vecs[1]  = '{4'hF, 16'h7000, 3'd0, 16'h0000, 10};
        vecs[2]  = '{4'hF, 16'h7000, 3'd6, 16'h3FFF, 10};
        vecs[3]  = '{4'hF, 16'h9000, 3'd7, 16'h8000, 10};
        vecs[4]  = '{4'hF, 16'h9000, 3'd4, 16'hF000, 10};
        vecs[5]  = '{4'h1, 16'h1234, 3'd7, 16'h1234, 7};
        vecs[6]  = '{4'h0, 16'h7000, 3'd7, 16'h0000, 6};
        vecs[7]  = '{4'h3, 16'h0100, 3'd5, 16'h0080, 8};
        vecs[8]  = '{4'h5, 16'hFFFF, 3'd7, 16'hFFFE, 8};
        vecs[9]  = '{4'hF, 16'h4000, 3'd7, 16'h7FFF, 10};
        vecs[10] = '{4'h3, 16'h4000, 3'd7, 16'h7FFF, 8};
        vecs[11] = '{4'h3, 16'hC000, 3'd7, 16'h8000, 8};
        vecs[12] = '{4'h1, 16'h8000, 3'd1, 16'hFE00, 7};
        for (int i = 0; i < NVEC; i++) begin
            for (int v = 0; v < NV; v++) begin
                voice_base[v*AW +: AW] = AW'(v * 16);
                voice_len[v*AW +: AW]  = AW'(1);
                mem[v*16]              = vecs[i].word;
                pattern[v*16 +: 16]    = vecs[i].mask[v] ? 16'hFFFF : 16'h0000;
            end
            volume = vecs[i].vol;
            do_frame(1'b1, 1'b0, ga, gl, ga1);
            check($sformatf("vec%0d_audio", i), 32'(ga), 32'(vecs[i].exp_audio));
            check($sformatf("vec%0d_latency", i), 32'(gl), 32'(vecs[i].exp_lat));
        end

        // ramp ROM: one voice walks through a 3-sample region
        do_reset();
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'(i);
        pattern    = '0;
        pattern[0] = 1'b1;
        voice_base = '0;
        voice_len  = '0;
        voice_base[0 +: AW] = AW'(100);
        voice_len[0 +: AW]  = AW'(3);
        volume = 3'd7;
        pulse_step();
        for (int k = 0; k < 3; k++) begin
            repeat (10) @(posedge clk);
            do_frame(1'b0, 1'b0, ga, gl, ga1);
            check($sformatf("ramp%0d_addr", k), 32'(ga1), 32'(100 + k));
            check($sformatf("ramp%0d_audio", k), 32'(ga), 32'(100 + k));
        end
        check("ramp_active", 32'(active), 32'd0);
        check("ramp_step", 32'(step), 32'd1);

        // step wrap: only step 15 fires
        do_reset();
        pattern     = '0;
        pattern[15] = 1'b1;
        voice_base  = '0;
        voice_len   = '0;
        voice_len[0 +: AW] = AW'(2);
        check("wrap_step_start", 32'(step), 32'd0);
        repeat (15) pulse_step();
        do_frame(1'b0, 1'b0, ga, gl, ga1);
        check("wrap_early_latency", 32'(gl), 32'd6);
        check("wrap_early_active", 32'(active), 32'd0);
        pulse_step();
        check("wrap_step_zero", 32'(step), 32'd0);
        do_frame(1'b0, 1'b0, ga, gl, ga1);
        check("wrap_fire_latency", 32'(gl), 32'd7);
        check("wrap_fire_active", 32'(active), 32'd1);

        // sample_tick re-pulsed three cycles into a frame is dropped
        do_reset();
        pattern = '0;
        pattern[0 +: 16] = 16'hFFFF;
        voice_len[0 +: AW] = AW'(2);
        pulse_step();
        start = av_count;
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("repulse_valid_count", 32'(av_count - start), 32'd1);
        check("repulse_busy", 32'(busy), 32'd0);
`ifdef DVS_OVERRUN_CNT_EN
        check("repulse_overrun_cnt", 32'(overrun_cnt), 32'd1);
`endif

        // reset during ACC of a two-voice frame
        do_reset();
        pattern = '0;
        pattern[0 +: 16]  = 16'hFFFF;
        pattern[16 +: 16] = 16'hFFFF;
        voice_base = '0;
        voice_len  = '0;
        voice_base[0 +: AW]  = AW'(10);
        voice_base[AW +: AW] = AW'(20);
        voice_len[0 +: AW]   = AW'(4);
        voice_len[AW +: AW]  = AW'(4);
        pulse_step();
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        @(posedge clk); #1;
        check("midrst_pre_busy", 32'(busy), 32'd1);
        check("midrst_pre_active", 32'(active), 32'h3);
        reset = 1'b0;
        #1;
        check("midrst_audio", 32'(audio), 32'd0);
        check("midrst_audio_valid", 32'(audio_valid), 32'd0);
        check("midrst_step", 32'(step), 32'd0);
        check("midrst_active", 32'(active), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rom_addr", 32'(rom_addr), 32'd0);
        start = av_count;
        @(posedge clk); #1 reset = 1'b1;
        m_reset();
        repeat (25) @(posedge clk);
        @(negedge clk);
        check("midrst_no_valid", 32'(av_count - start), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);

        // randomized traffic against the model
        do_reset();
        for (int v = 0; v < NV; v++) begin
            voice_base[v*AW +: AW] = AW'($urandom);
            voice_len[v*AW +: AW]  = ($urandom_range(0, 5) == 0) ? AW'(0) : AW'($urandom_range(1, 6));
            pattern[v*16 +: 16]    = 16'($urandom);
        end
        for (int i = 0; i < (1 << AW); i++)
            mem[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 4000) - 2000);
        volume = 3'($urandom);
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 7) == 0) pattern = {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) volume = 3'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                pulse_step();
            end else begin
                do_frame(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ga, gl, ga1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
